// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch buffer entry layout.
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0033;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head data is read combinationally.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_data   = r_mem[r_rdPtr];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_doPush = i_push && (!o_full || i_pop);
   assign w_doPop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
         r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_data;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch front end: credit-limited imem requests, in-order
// responses matched to a PC queue, and a small instruction buffer feeding IF/ID.
module if_fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH       = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic        fetch_empty
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam int PW = $clog2(MAX_OUTSTANDING) + 1;

   logic [31:0]    r_fetchPc;
   logic [CW-1:0]  r_outstanding;
   logic [CW-1:0]  r_killCount;

   logic           w_reqFire;
   logic           w_killActive;
   logic           w_rspKeep;
   logic [CW:0]    w_credits;
   logic [31:0]    w_pcqHead;
   logic           w_pcqFull;
   logic           w_pcqEmpty;
   logic [PW-1:0]  w_pcqCount;
   fetch_entry_t   w_bufHead;
   fetch_entry_t   w_bufIn;
   logic           w_bufPop;
   logic           w_bufFull;
   logic           w_bufEmpty;
   logic [CW-1:0]  w_bufCount;

   // Credits count both in-flight requests and buffered instructions so every
   // surviving response is guaranteed a buffer slot.
   assign w_credits      = {1'b0, r_outstanding} + {1'b0, w_bufCount};
   assign imem_req_valid = rst && !redirect_valid && !w_pcqFull
                           && (r_outstanding < CW'(MAX_OUTSTANDING))
                           && (w_credits < (CW+1)'(BUF_DEPTH));
   assign imem_req_addr  = r_fetchPc;
   assign w_reqFire      = imem_req_valid && imem_req_ready;

   assign w_killActive   = (r_killCount != '0);
   assign w_rspKeep      = imem_rsp_valid && !w_killActive && !redirect_valid;
   assign w_bufPop       = !stall && !w_bufEmpty && !redirect_valid;
   assign w_bufIn        = '{pc: w_pcqHead, instr: imem_rsp_data};

   fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(32)) u_pcQueue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_reqFire),
      .i_data  (r_fetchPc),
      .i_pop   (w_rspKeep),
      .i_flush (redirect_valid),
      .o_data  (w_pcqHead),
      .o_full  (w_pcqFull),
      .o_empty (w_pcqEmpty),
      .o_count (w_pcqCount)
   );

   fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(64)) u_instrBuf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rspKeep),
      .i_data  (w_bufIn),
      .i_pop   (w_bufPop),
      .i_flush (redirect_valid),
      .o_data  (w_bufHead),
      .o_full  (w_bufFull),
      .o_empty (w_bufEmpty),
      .o_count (w_bufCount)
   );

   // On redirect every request still in flight is wrong-path, minus the one
   // answering this very cycle, which is dropped on the spot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetchPc     <= RESET_PC;
         r_outstanding <= '0;
         r_killCount   <= '0;
      end else if (redirect_valid) begin
         r_fetchPc     <= redirect_pc;
         r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
         r_killCount   <= r_outstanding - CW'(imem_rsp_valid);
      end else begin
         if (w_reqFire) r_fetchPc <= r_fetchPc + 32'd4;
         r_outstanding <= r_outstanding + CW'(w_reqFire) - CW'(imem_rsp_valid);
         if (imem_rsp_valid && w_killActive) r_killCount <= r_killCount - CW'(1);
      end
   end

   assign fetch_empty = w_bufEmpty;
   assign InstrF      = w_bufEmpty ? NOP_INSTR : w_bufHead.instr;
   assign PCF         = w_bufEmpty ? 32'h0 : w_bufHead.pc;
   assign PCPlus4F    = w_bufEmpty ? 32'h0 : (w_bufHead.pc + 32'd4);

   a_rspWithoutRequest: assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> (r_outstanding != '0));

   a_rspHasPc: assert property (@(posedge clk) disable iff (!rst)
      w_rspKeep |-> !w_pcqEmpty);

   a_bufHasRoom: assert property (@(posedge clk) disable iff (!rst)
      w_rspKeep |-> (!w_bufFull || w_bufPop));

   a_pcqTracksOutstanding: assert property (@(posedge clk) disable iff (!rst)
      CW'(w_pcqCount) <= r_outstanding);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-bench memory of selectable
// latency that answers each accepted request with addr+0x100.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic        fetch_empty;

   int total;
   int bad;
   int lat;

   typedef struct {
      logic [31:0] addr;
      int          rem;
   } memEntry_t;

   memEntry_t memQ[$];

   if_fetch_unit #(
      .RESET_PC        (32'h0000_0000),
      .BUF_DEPTH       (2),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .InstrF         (InstrF),
      .PCF            (PCF),
      .PCPlus4F       (PCPlus4F),
      .fetch_empty    (fetch_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic checkReq(input string tag, input logic v, input logic [31:0] addr);
      checkOutput({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
      if (v) checkOutput({tag, ".req_addr"}, imem_req_addr, addr);
   endtask

   task automatic checkBubble(input string tag);
      checkOutput({tag, ".empty"}, {31'b0, fetch_empty}, 32'd1);
      checkOutput({tag, ".InstrF"}, InstrF, 32'h0000_0033);
      checkOutput({tag, ".PCF"}, PCF, 32'h0);
      checkOutput({tag, ".PCPlus4F"}, PCPlus4F, 32'h0);
   endtask

   task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      checkOutput({tag, ".empty"}, {31'b0, fetch_empty}, 32'd0);
      checkOutput({tag, ".InstrF"}, InstrF, instr);
      checkOutput({tag, ".PCF"}, PCF, pc);
      checkOutput({tag, ".PCPlus4F"}, PCPlus4F, pc + 32'd4);
   endtask

   task automatic applyStimulus(input logic st, input logic rdy, input logic rv, input logic [31:0] rpc);
      stall          = st;
      imem_req_ready = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
   endtask

   // One clock: sample the handshake before the edge, then advance the memory.
   task automatic tick();
      logic        fire;
      logic [31:0] a;
      logic        presenting;
      memEntry_t   e;
      @(negedge clk);
      fire       = imem_req_valid && imem_req_ready;
      a          = imem_req_addr;
      presenting = imem_rsp_valid;
      @(posedge clk);
      #1;
      if (presenting) void'(memQ.pop_front());
      for (int i = 0; i < memQ.size(); i++)
         if (memQ[i].rem > 0) memQ[i].rem = memQ[i].rem - 1;
      if (fire) begin
         e.addr = a;
         e.rem  = lat - 1;
         memQ.push_back(e);
      end
      if (memQ.size() > 0 && memQ[0].rem == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memQ[0].addr + 32'h100;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic holdReset();
      rst = 1'b0;
      memQ.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      #1;
   endtask

   task automatic releaseReset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      lat   = 1;
      stall = 1'b0;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      holdReset();
      @(posedge clk);
      #1;
      checkReq("reset", 1'b0, 32'h0);
      checkBubble("reset");
      releaseReset();

      // Streaming with a 1-cycle memory.
      checkReq("s0", 1'b1, 32'h0);   checkBubble("s0");   tick();
      checkReq("s1", 1'b1, 32'h4);   checkBubble("s1");   tick();
      checkReq("s2", 1'b0, 32'h0);   checkHead("s2", 32'h0, 32'h100);   tick();
      checkReq("s3", 1'b1, 32'h8);   checkHead("s3", 32'h4, 32'h104);   tick();
      checkReq("s4", 1'b1, 32'hC);   checkBubble("s4");   tick();

      // Stall for three cycles with the buffer filling to two entries.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkReq("st5", 1'b0, 32'h0);  checkHead("st5", 32'h8, 32'h108);  tick();
      checkReq("st6", 1'b0, 32'h0);  checkHead("st6", 32'h8, 32'h108);  tick();
      checkReq("st7", 1'b0, 32'h0);  checkHead("st7", 32'h8, 32'h108);  tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkReq("st8", 1'b0, 32'h0);  checkHead("st8", 32'h8, 32'h108);  tick();
      checkReq("st9", 1'b1, 32'h10); checkHead("st9", 32'hC, 32'h10C);  tick();

      // Memory not ready for four cycles.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkReq("nr10", 1'b1, 32'h14); checkBubble("nr10"); tick();
      checkReq("nr11", 1'b1, 32'h14); checkHead("nr11", 32'h10, 32'h110); tick();
      checkReq("nr12", 1'b1, 32'h14); checkBubble("nr12"); tick();
      checkReq("nr13", 1'b1, 32'h14); checkBubble("nr13"); tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkReq("nr14", 1'b1, 32'h14); checkBubble("nr14"); tick();
      checkReq("nr15", 1'b1, 32'h18); checkBubble("nr15");

      // Redirect with two requests in flight to a 3-cycle memory.
      holdReset();
      lat = 3;
      releaseReset();
      checkReq("r0", 1'b1, 32'h0);   tick();
      checkReq("r1", 1'b1, 32'h4);   tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
      checkReq("r2", 1'b0, 32'h0);   checkBubble("r2");   tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkReq("r3", 1'b0, 32'h0);   checkBubble("r3");   tick();
      checkReq("r4", 1'b1, 32'h200); checkBubble("r4");   tick();
      checkReq("r5", 1'b1, 32'h204); checkBubble("r5");   tick();
      checkReq("r6", 1'b0, 32'h0);   checkBubble("r6");   tick();
      checkBubble("r7");             tick();

      // Redirect coinciding with a response while stalled.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h400);
      checkOutput("r8.rsp_valid", {31'b0, imem_rsp_valid}, 32'd1);
      checkReq("r8", 1'b0, 32'h0);   checkHead("r8", 32'h200, 32'h300); tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkReq("r9", 1'b1, 32'h400); checkBubble("r9");   tick();
      checkReq("r10", 1'b1, 32'h404); tick();
      checkReq("r11", 1'b0, 32'h0);  checkBubble("r11");  tick();
      checkBubble("r12");            tick();
      checkReq("r13", 1'b0, 32'h0);  checkHead("r13", 32'h400, 32'h500); tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkReq("r14", 1'b0, 32'h0);  checkHead("r14", 32'h400, 32'h500); tick();
      checkReq("r15", 1'b1, 32'h408); checkHead("r15", 32'h404, 32'h504); tick();
      checkReq("r16", 1'b1, 32'h40C); checkBubble("r16"); tick();
      checkReq("r17", 1'b0, 32'h0);  checkBubble("r17");

      // Reset asserted with two requests outstanding.
      holdReset();
      checkReq("mr", 1'b0, 32'h0);
      checkBubble("mr");
      lat = 1;
      releaseReset();
      checkReq("mr0", 1'b1, 32'h0);  checkBubble("mr0");  tick();
      checkReq("mr1", 1'b1, 32'h4);  checkBubble("mr1");  tick();
      checkReq("mr2", 1'b0, 32'h0);  checkHead("mr2", 32'h0, 32'h100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
